// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - program RAM loaded from a framed, checksummed byte stream
module prog_mem_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;
  // LEN byte of zero stands for a full-memory image, which needs one extra count bit.
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(LOAD_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_cnt;
  logic [DATA_W-1:0] csum_total;
  logic              xfer;
  logic              len_take;
  logic              data_take;

  // Stream-facing flags are pure decodes of the state register, so they never look at s_valid.
  assign s_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy     = s_ready;
  assign cpu_run  = (state == S_DONE);
  assign load_err = (state == S_ERR);

  assign xfer       = s_valid && s_ready;
  assign len_cnt    = (s_data == '0) ? FULL_CNT : (ADDR_W+1)'(s_data);
  assign csum_total = sum + s_data;

  // Asynchronous read port: same-cycle writes show up only after the edge.
  assign rd_data = mem[rd_addr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; start overrides any coincident byte.
  always_comb begin
    state_nxt = state;
    len_take  = 1'b0;
    data_take = 1'b0;
    if (start) begin
      state_nxt = S_LEN;
    end else begin
      case (state)
        S_LEN: begin
          if (xfer) begin
            len_take  = 1'b1;
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            data_take = 1'b1;
            if (remaining == ONE_CNT) begin
              state_nxt = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state_nxt = (csum_total == '0) ? S_DONE : S_ERR;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Frame bookkeeping: write pointer, running sum, byte counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= BASE;
      sum          <= '0;
      remaining    <= '0;
      words_loaded <= '0;
    end else if (len_take) begin
      ptr          <= BASE;
      sum          <= '0;
      remaining    <= len_cnt;
      words_loaded <= '0;
    end else if (data_take) begin
      ptr          <= ptr + 1'b1;
      sum          <= sum + s_data;
      remaining    <= remaining - ONE_CNT;
      words_loaded <= words_loaded + ONE_CNT;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (data_take) begin
      mem[ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb/tb_prog_mem_loader.sv - randomized self-checking bench for prog_mem_loader
`timescale 1ns/100ps
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [7:0] rd_addr = 8'h00;

  logic       s_ready_a, cpu_run_a, load_err_a, busy_a;
  logic [7:0] rd_data_a;
  logic [8:0] words_a;
  logic       s_ready_b, cpu_run_b, load_err_b, busy_b;
  logic [7:0] rd_data_b;
  logic [8:0] words_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl_a [256];
  logic [7:0] mdl_b [256];
  bit         wr_a  [256];
  bit         wr_b  [256];
  logic [7:0] dq [$];

  always #5 clk = ~clk;

  prog_mem_loader #(.DATA_W(8), .ADDR_W(8), .LOAD_BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_a), .rd_addr(rd_addr), .rd_data(rd_data_a), .cpu_run(cpu_run_a),
    .load_err(load_err_a), .busy(busy_a), .words_loaded(words_a)
  );

  prog_mem_loader #(.DATA_W(8), .ADDR_W(8), .LOAD_BASE(254)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .rd_addr(rd_addr), .rd_data(rd_data_b), .cpu_run(cpu_run_b),
    .load_err(load_err_b), .busy(busy_b), .words_loaded(words_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected RAM: data byte i of a frame lands at (base + i) mod 256.
  task automatic model_write(input int idx, input logic [7:0] b);
    int aa;
    int ab;
    aa = idx % 256;
    ab = (254 + idx) % 256;
    mdl_a[aa] = b;
    wr_a[aa]  = 1'b1;
    mdl_b[ab] = b;
    wr_b[ab]  = 1'b1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after a random idle gap; the byte moves at the first edge with s_ready high.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    bit done;
    gap  = $urandom_range(0, max_gap);
    done = 1'b0;
    t    = 0;
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      tick();
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!done && t < 50) begin
      done = s_ready_a;
      tick();
      t++;
    end
    s_valid = 1'b0;
    check("handshake", 32'(done), 32'd1);
  endtask

  task automatic check_mem;
    for (int a = 0; a < 256; a++) begin
      if (wr_a[a] || wr_b[a]) begin
        @(negedge clk);
        rd_addr = 8'(a);
        #1;
        if (wr_a[a]) check($sformatf("mem_a[%0h]", a), 32'(rd_data_a), 32'(mdl_a[a]));
        if (wr_b[a]) check($sformatf("mem_b[%0h]", a), 32'(rd_data_b), 32'(mdl_b[a]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] good_csum();
    logic [7:0] s;
    s = 8'h00;
    foreach (dq[i]) s = s + dq[i];
    return 8'h00 - s;
  endfunction

  // Send a full frame built from dq and compare the outcome with the checksum rule.
  task automatic run_frame(input logic [7:0] len_b, input logic [7:0] csum_b, input int max_gap);
    logic [7:0] total;
    bit         ok;
    total = csum_b;
    pulse_start();
    check("busy_in_len", 32'(busy_a), 32'd1);
    check("run_drops_on_start", 32'(cpu_run_a), 32'd0);
    send_byte(len_b, max_gap);
    foreach (dq[i]) begin
      send_byte(dq[i], max_gap);
      model_write(i, dq[i]);
      total = total + dq[i];
    end
    send_byte(csum_b, max_gap);
    ok = (total == 8'h00);
    check("cpu_run_a", 32'(cpu_run_a), 32'(ok));
    check("load_err_a", 32'(load_err_a), 32'(!ok));
    check("cpu_run_b", 32'(cpu_run_b), 32'(ok));
    check("load_err_b", 32'(load_err_b), 32'(!ok));
    check("busy_after", 32'(busy_a), 32'd0);
    check("s_ready_after", 32'(s_ready_a), 32'd0);
    check("words_a", 32'(words_a), 32'(dq.size()));
    check("words_b", 32'(words_b), 32'(dq.size()));
    check_mem();
  endtask

  initial begin
    int         len;
    logic [7:0] cs;

    // Reset state
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready_a), 32'd0);
    check("rst_cpu_run", 32'(cpu_run_a), 32'd0);
    check("rst_load_err", 32'(load_err_a), 32'd0);
    check("rst_busy", 32'(busy_b), 32'd0);
    check("rst_words", 32'(words_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // Bytes offered in IDLE are ignored
    s_valid = 1'b1;
    s_data  = 8'h77;
    repeat (3) tick();
    s_valid = 1'b0;
    check("idle_ignore_busy", 32'(busy_a), 32'd0);
    check("idle_ignore_words", 32'(words_a), 32'd0);

    // Reference frame with good and bad checksums
    dq = '{8'h00, 8'h05, 8'h01};
    run_frame(8'h03, 8'hFA, 0);
    @(negedge clk);
    rd_addr = 8'h01;
    #1;
    check("rd_addr1", 32'(rd_data_a), 32'h05);
    tick();
    run_frame(8'h03, 8'hFB, 1);
    run_frame(8'h03, 8'hFA, 2);

    // Wrap frame (shown on the base-FE instance)
    dq = '{8'h11, 8'h22, 8'h33};
    run_frame(8'h03, 8'h9A, 1);

    // Bytes offered in DONE are ignored
    s_valid = 1'b1;
    repeat (4) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
    check("done_hold_run", 32'(cpu_run_a), 32'd1);
    check("done_hold_words", 32'(words_a), 32'd3);
    check_mem();

    // Full-memory frame, LEN=0
    dq = {};
    for (int i = 0; i < 256; i++) dq.push_back(8'h01);
    run_frame(8'h00, 8'h00, 0);

    // Random frames with random gaps and random checksum quality
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 40);
      dq  = {};
      for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
      cs = good_csum();
      if ($urandom_range(0, 1) == 0) cs = cs + 8'($urandom_range(1, 255));
      run_frame(8'(len), cs, 3);
      // ERR state must also ignore stream bytes
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      tick();
      s_valid = 1'b0;
      check("post_frame_words", 32'(words_a), 32'(len));
    end

    // Abort after one data byte; a coincident byte with start is dropped
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'hA7, 0);
    model_write(0, 8'hA7);
    check("abort_words1", 32'(words_a), 32'd1);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5C;
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd1);
    check("abort_words_kept", 32'(words_a), 32'd1);
    check_mem();
    dq = '{8'h10, 8'h20, 8'h30};
    run_frame(8'h03, good_csum(), 1);

    // Asynchronous reset mid-DATA keeps written bytes
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'hC1, 0);
    model_write(0, 8'hC1);
    send_byte(8'hC2, 0);
    model_write(1, 8'hC2);
    check("mid_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_s_ready", 32'(s_ready_a), 32'd0);
    check("arst_cpu_run", 32'(cpu_run_b), 32'd0);
    check("arst_words", 32'(words_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_mem();
    dq = '{8'h42};
    run_frame(8'h01, good_csum(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
